// File: rtl/cnn_layer_accel_seq_loader.sv
// cnn_layer_accel_seq_loader: unpacks 128-bit network packets into 16-bit words
// and writes exactly cfg_num_words of them to the sequence BRAM from address 0.
module cnn_layer_accel_seq_loader #(
   parameter int C_PACKET_WIDTH    = 128,
   parameter int C_SEQ_DATA_WIDTH  = 16,
   parameter int C_BRAM_DEPTH      = 512,
   localparam int C_LOG2_BRAM_DEPTH = $clog2(C_BRAM_DEPTH)
) (
   input  logic                          i_network_clk,
   input  logic                          i_network_rst,
   input  logic                          i_start,
   input  logic [C_LOG2_BRAM_DEPTH:0]    i_cfg_num_words,
   output logic                          o_busy,
   output logic                          o_done,
   input  logic                          i_from_network_valid,
   output logic                          o_from_network_accept,
   input  logic [C_PACKET_WIDTH-1:0]     i_from_network_payload,
   output logic                          o_seq_wren,
   output logic [C_LOG2_BRAM_DEPTH-1:0]  o_seq_addr,
   output logic [C_SEQ_DATA_WIDTH-1:0]   o_seq_data,
   input  logic                          i_seq_accept
);
   localparam int L = C_LOG2_BRAM_DEPTH;
   localparam logic [L:0] ONE   = {{L{1'b0}}, 1'b1};
   localparam logic [L:0] DEPTH = (L+1)'(C_BRAM_DEPTH);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   state_t                      r_state;
   logic [C_PACKET_WIDTH-1:0]   r_hold;
   logic                        r_hold_vld;
   logic                        r_done;
   logic [2:0]                  r_idx;
   logic [L-1:0]                r_addr;
   logic [L:0]                  r_rem;
   logic [C_SEQ_DATA_WIDTH-1:0] w_word [8];
   logic [3:0]                  w_buffered;
   logic [L:0]                  w_cfg_clamp;
   logic                        w_wr;
   logic                        w_last;
   logic                        w_take;
   logic                        w_pkts_needed;
   // word0 sits in the most significant slice of the payload
   for (genvar i = 0; i < 8; i++) begin : g_word
      assign w_word[i] = r_hold[C_PACKET_WIDTH-1-i*C_SEQ_DATA_WIDTH -: C_SEQ_DATA_WIDTH];
   end
   assign w_buffered            = r_hold_vld ? 4'd8 - {1'b0, r_idx} : 4'd0;
   assign w_pkts_needed         = r_rem > {{(L-3){1'b0}}, w_buffered};
   assign w_wr                  = r_hold_vld & i_seq_accept;
   assign w_last                = w_wr & ((r_idx == 3'd7) | (r_rem == ONE));
   assign w_cfg_clamp           = (i_cfg_num_words > DEPTH) ? DEPTH : i_cfg_num_words;
   assign o_from_network_accept = (r_state == LOAD) & w_pkts_needed & (~r_hold_vld | w_last);
   assign w_take                = i_from_network_valid & o_from_network_accept;
   assign o_busy                = (r_state == LOAD);
   assign o_done                = r_done;
   assign o_seq_wren            = r_hold_vld;
   assign o_seq_addr            = r_addr;
   assign o_seq_data            = w_word[r_idx];
   always_ff @(posedge i_network_clk or posedge i_network_rst) begin
      if (i_network_rst) begin
         r_state    <= IDLE;
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
         r_done     <= 1'b0;
         r_idx      <= '0;
         r_addr     <= '0;
         r_rem      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (i_start) begin
               if (i_cfg_num_words == '0) r_done <= 1'b1;
               else begin
                  r_state    <= LOAD;
                  r_rem      <= w_cfg_clamp;
                  r_addr     <= '0;
                  r_idx      <= '0;
                  r_hold_vld <= 1'b0;
               end
            end
            LOAD: begin
               if (w_wr) begin
                  r_addr <= r_addr + 1'b1;
                  r_idx  <= r_idx + 1'b1;
                  r_rem  <= r_rem - 1'b1;
               end
               // a new packet refills the register in the same cycle the last word leaves
               if (w_take) begin
                  r_hold     <= i_from_network_payload;
                  r_hold_vld <= 1'b1;
                  r_idx      <= '0;
               end else if (w_last) r_hold_vld <= 1'b0;
               if (w_wr && r_rem == ONE) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cnn_layer_accel_seq_loader.sv
// tb_cnn_layer_accel_seq_loader: directed loads checked every cycle against a
// word-stream model (write k must carry word k%8 of packet k/8 at address k).
module tb_cnn_layer_accel_seq_loader;
   logic         clk = 1'b0;
   logic         rst;
   logic         i_start;
   logic [9:0]   i_cfg;
   logic         o_busy, o_done;
   logic         i_valid;
   logic         o_accept;
   logic [127:0] i_payload;
   logic         o_wren;
   logic [8:0]   o_addr;
   logic [15:0]  o_data;
   logic         i_seq_accept;
   int n_cmp = 0, n_bad = 0;
   int wcount = 0, acnt = 0, dcnt = 0, n_eff = 0, cyc = 0, last_wr = 0, last_addr = 0;
   int gap = 0, gap_cnt = 0, drv_last = 0;
   bit in_load = 0, exp_done0 = 0, acc_toggle = 0, stall_prev = 0;
   logic [8:0]  p_addr;
   logic [15:0] p_data, first_data;

   always #5 clk = ~clk;

   cnn_layer_accel_seq_loader dut (
      .i_network_clk(clk), .i_network_rst(rst), .i_start(i_start), .i_cfg_num_words(i_cfg),
      .o_busy(o_busy), .o_done(o_done), .i_from_network_valid(i_valid),
      .o_from_network_accept(o_accept), .i_from_network_payload(i_payload),
      .o_seq_wren(o_wren), .o_seq_addr(o_addr), .o_seq_data(o_data), .i_seq_accept(i_seq_accept));

   function automatic logic [15:0] wd(int p, int j);
      return 16'(((p * 8 + j) * 263) ^ 50085);
   endfunction

   function automatic logic [127:0] mk_pkt(int p);
      logic [127:0] r;
      for (int j = 0; j < 8; j++) r[127-16*j -: 16] = wd(p, j);
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic sample();
      cyc++;
      if (rst) begin
         in_load = 0; stall_prev = 0; exp_done0 = 0;
         return;
      end
      if (stall_prev) begin
         chk("stall_wren", o_wren, 1);
         chk("stall_addr", o_addr, p_addr);
         chk("stall_data", o_data, p_data);
      end
      stall_prev = o_wren && !i_seq_accept;
      p_addr = o_addr; p_data = o_data;
      chk("busy", o_busy, in_load && !o_done);
      if (o_wren && i_seq_accept) begin
         chk("wr_in_load", in_load, 1);
         chk("wr_addr", o_addr, wcount);
         chk("wr_data", o_data, wd(wcount / 8, wcount % 8));
         if (wcount == 0) first_data = o_data;
         wcount++; last_wr = cyc; last_addr = int'(o_addr);
      end
      if (o_accept && i_valid) begin
         chk("acc_pkt_end", acnt * 8, wcount);
         chk("acc_needed", n_eff > acnt * 8, 1);
         acnt++;
      end
      if (o_done) dcnt++;
      if (exp_done0) begin
         chk("done_zero", o_done, 1);
         exp_done0 = 0;
      end else if (o_done) begin
         chk("done_in_load", in_load, 1);
         chk("done_len", wcount, n_eff);
         chk("done_lat", cyc - last_wr, 1);
      end
      if (i_start && !in_load) begin
         wcount = 0; acnt = 0; dcnt = 0;
         n_eff = (int'(i_cfg) > 512) ? 512 : int'(i_cfg);
         in_load = (n_eff > 0);
         exp_done0 = (n_eff == 0);
      end else if (o_done) in_load = 0;
   endtask

   task automatic drive();
      if (acnt != drv_last) begin
         i_valid = 1'b0;
         gap_cnt = gap;
      end
      drv_last = acnt;
      if (!i_valid) begin
         if (gap_cnt > 0) gap_cnt--;
         else i_valid = 1'b1;
      end
      i_payload = mk_pkt(acnt);
      i_seq_accept = acc_toggle ? !i_seq_accept : 1'b1;
   endtask

   task automatic cycle();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run(int cfg, int ex_writes, int ex_acc, int mid);
      i_cfg = 10'(cfg); i_start = 1'b1;
      cycle();
      i_start = 1'b0;
      for (int k = 0; k < 2000 && dcnt == 0; k++) begin
         i_start = (k == mid);
         if (k == mid) i_cfg = 10'd3;
         cycle();
      end
      i_start = 1'b0;
      chk("done_seen", dcnt, 1);
      cycle(); cycle();
      chk("done_once", dcnt, 1);
      chk("n_writes", wcount, ex_writes);
      chk("n_pkts", acnt, ex_acc);
      chk("busy_end", o_busy, 0);
      if (ex_writes > 0) begin
         chk("first_data", first_data, 16'hC3A5);
         chk("last_addr", last_addr, ex_writes - 1);
      end
   endtask

   initial begin
      rst = 1'b1; i_start = 1'b0; i_cfg = '0; i_valid = 1'b0; i_payload = '0; i_seq_accept = 1'b1;
      chk("model_w00", wd(0, 0), 16'hC3A5);
      chk("model_w12", wd(1, 2), 16'hC9E3);
      chk("model_pkt0_lo", mk_pkt(0) & 128'hFFFF, 128'hC494);
      cycle(); cycle();
      chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0); chk("rst_acc", o_accept, 0);
      chk("rst_wren", o_wren, 0); chk("rst_addr", o_addr, 0); chk("rst_data", o_data, 0);
      rst = 1'b0;
      cycle();
      run(16, 16, 2, -1);
      run(10, 10, 2, -1);
      acc_toggle = 1;
      run(24, 24, 3, -1);
      acc_toggle = 0; gap = 3;
      run(24, 24, 3, -1);
      gap = 0;
      run(0, 0, 0, -1);
      run(600, 512, 64, -1);
      run(16, 16, 2, 5);
      i_cfg = 10'd16; i_start = 1'b1;
      cycle();
      i_start = 1'b0;
      for (int k = 0; k < 100 && wcount < 6; k++) cycle();
      chk("pre_rst_writes", wcount, 6);
      rst = 1'b1;
      #1;
      chk("arst_busy", o_busy, 0); chk("arst_done", o_done, 0); chk("arst_acc", o_accept, 0);
      chk("arst_wren", o_wren, 0); chk("arst_addr", o_addr, 0); chk("arst_data", o_data, 0);
      cycle(); cycle();
      rst = 1'b0;
      cycle();
      run(8, 8, 1, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
